// File: rtl/led_counter_gen2.sv
// led_counter_gen2: free-running LED counter with a clock-enable prescaler,
// up/down counting, parallel load and wrap / saturate / one-shot boundaries.
// LEDs show the counter MSBs. tick and wrap_pulse are one-cycle pulses that
// line up with the new count value.
module led_counter_gen2 #(
  parameter int               WIDTH    = 32,
  parameter int               LED_W    = 16,
  parameter int               PRESCALE = 1,
  parameter logic [WIDTH-1:0] TOP      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             wrap_pulse,
  output logic             overflow_flag,
  output logic             done
);

  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] M_SAT = 2'b01;
  localparam logic [1:0] M_ONE = 2'b10;

  logic [PS_W-1:0]  ps;
  logic             halted;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  // A finished one-shot freezes the prescaler as well as the count.
  assign halted       = done && (mode == M_ONE);
  assign at_bound     = dir ? (count == '0) : (count == TOP);
  assign load_clamped = (load_value > TOP) ? TOP : load_value;
  assign led          = count[WIDTH-1 -: LED_W];

  // Prescaler, counter, pulses and flags. Priority: reset > load > step.
  // clear_flag is ordered first so a boundary event in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      ps            <= '0;
      tick          <= 1'b0;
      wrap_pulse    <= 1'b0;
      overflow_flag <= 1'b0;
      done          <= 1'b0;
    end else begin
      tick       <= 1'b0;
      wrap_pulse <= 1'b0;
      if (mode != M_ONE) done          <= 1'b0;
      if (clear_flag)    overflow_flag <= 1'b0;
      if (load) begin
        count <= load_clamped;
        ps    <= '0;
        done  <= 1'b0;
      end else if (enable && !halted) begin
        if (ps == PS_LAST) begin
          ps   <= '0;
          tick <= 1'b1;
          if (at_bound) begin
            overflow_flag <= 1'b1;
            case (mode)
              M_SAT:   ;
              M_ONE:   done <= 1'b1;
              default: begin
                count      <= dir ? TOP : '0;
                wrap_pulse <= 1'b1;
              end
            endcase
          end else begin
            count <= dir ? count - 1'b1 : count + 1'b1;
          end
        end else begin
          ps <= ps + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/led_counter_gen2.md
# led_counter_gen2

Parametrised free-running LED counter: the general successor to the fixed 32-bit enable-only LED counter on the board. It adds configurable width, LED tap width and modulus, a clock-enable prescaler, up/down counting, parallel load, and three boundary modes: wrap, saturate and one-shot. Boundary events are reported as pulse, sticky and done flags. It sits between the board clock/reset and the LED bank, and also feeds timing ticks to other demo blocks.

## Interface
- WIDTH, 32: counter width in bits; must be at least 2.
- LED_W, 16: number of LED bits; must be at most WIDTH; driven from the counter MSBs.
- PRESCALE, 1: enabled cycles per count step; must be at least 1.
- TOP, {WIDTH{1'b1}}: maximum count value; the count range is 0..TOP.
- clk  in  1  board clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  advances the prescaler while high; when low, all state holds.
- dir  in  1  0 = count up, 1 = count down.
- mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value to load; a value above TOP is clamped to TOP.
- clear_flag  in  1  clears overflow_flag.
- count  out  WIDTH  current count (registered).
- led  out  LED_W  equal to count[WIDTH-1 -: LED_W].
- tick  out  1  one-cycle pulse for each prescaler terminal.
- wrap_pulse  out  1  one-cycle pulse for each actual wrap.
- overflow_flag  out  1  sticky flag for boundary events.
- done  out  1  one-shot terminal reached; the counter is halted.

## Operation
- **Prescaler.** Internal counter ps counts 0..PRESCALE-1 and advances only when enable=1.
  - A step is due when enable=1 and ps=PRESCALE-1; ps then returns to 0.
  - With PRESCALE=1, a step is due on every enabled cycle.
- **Priority.** reset > load > step.
- **Load.** Sets count to min(load_value, TOP), sets ps to 0 and clears done. No step occurs that cycle, even if one was due.
- **Boundary.** A boundary is reached when count=TOP with dir=0, or count=0 with dir=1. For a due step that is not at a boundary, count moves by ±1.
- **Due step at a boundary, by mode:**
  - wrap / 11: count goes to 0 (counting up) or TOP (counting down); wrap_pulse fires; overflow_flag sets.
  - saturate: count holds; overflow_flag sets on every such step; no wrap_pulse.
  - one-shot: count holds; done sets; overflow_flag sets.
- **done behaviour.**
  - While done=1 and mode=10, steps are suppressed: ps and count hold, and tick is not generated.
  - done clears on reset, on load, or on any cycle where mode≠10.
- **Mode changes.** mode may change on any cycle. The new mode takes effect on the next due step; count is never modified by a mode change alone.
- **overflow_flag.**
  - Set when a boundary event occurs; cleared by clear_flag.
  - If a set and a clear occur in the same cycle, the set wins.
- **Direction changes.** dir changes take effect on the next step; there is no pipeline.

## Timing
- **Reset values** (reset high at a rising edge): count=0, led=0, ps=0, tick=0, wrap_pulse=0, overflow_flag=0, done=0.
- **Reset mid-operation:** the reset values apply at that edge, regardless of load, enable or any pending step.
- **Latency:**
  - count changes at the same edge where the step is due or load is sampled.
  - led is a combinational slice of the count register, so it adds no extra latency.
- **Pulses and flags:**
  - tick and wrap_pulse are registered. Each is high for exactly the one cycle following the step edge, i.e. concurrent with the new count value.
  - overflow_flag and done rise at that same edge.
- **Throughput:**
  - Maximum step rate is one step per PRESCALE enabled cycles.
  - enable gaps stretch the period without losing prescaler phase.
- All outputs are registered or are direct slices of registers; there is no combinational path from input to output.

## Test plan
- **Basic up-count.** WIDTH=8, LED_W=4, PRESCALE=4, TOP=255, mode=00, dir=0, enable held high for 1024 cycles.
  - count=0 after 1024 cycles (one wrap); tick fires every 4th cycle; wrap_pulse fires exactly once, concurrent with count=0; led tracks count[7:4].
- **Modulus wrap, both directions.** TOP=9, PRESCALE=1, mode=00.
  - Counting up from 0: sequence 0..9,0; wrap_pulse on the return to 0.
  - Then dir=1: sequence 0,9,8; wrap_pulse on the 0→9 transition.
- **Saturate.** Load 250 with TOP=255, mode=01, up, 10 steps.
  - count sticks at 255; overflow_flag=1; wrap_pulse never asserts.
  - clear_flag together with a further step at the limit: flag stays 1 (set wins).
  - clear_flag alone: flag goes to 0.
- **One-shot.** mode=10, TOP=9, start at 0, enable high.
  - done rises concurrent with the first step that was attempted with count already at 9 (count=9 throughout); tick stops afterwards.
  - load 3: done=0, counting resumes 3,4,…
- **Load priority.** load=1 with load_value=300, TOP=255, and a step due in the same cycle.
  - count=255, ps=0, no tick.
- **Reset mid-run.** Assert reset with count=0x7F, overflow_flag=1, done=1 and load=1 all at once.
  - Next cycle: all outputs 0.
  - The first tick after reset release comes PRESCALE enabled cycles later.
